// File: rtl/credit_link_tx.sv
// Credit-based flit transmitter: buffers crossbar flits and forwards them on
// the link only while the downstream receive FIFO has free space.
`ifndef DW
`define DW 32
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif

module credit_link_tx #(
    parameter int DW         = `DW,
    parameter int CREDIT_MAX = 4,
    parameter int CREDIT_W   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_LOG   = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic [DW-1:0]       data_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [DW-1:0]       data_o,
    input  logic                credit_upd_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                in_pkt_o,
    output logic [15:0]         pkt_cnt_o,
    output logic                err_o
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [CREDIT_W-1:0] CMAX     = CREDIT_W'(CREDIT_MAX);
    localparam logic [FIFO_LOG:0]   FULL_CNT = (FIFO_LOG + 1)'(FIFO_DEPTH);

    logic [DW-1:0]       mem [FIFO_DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr;
    logic [FIFO_LOG-1:0] rd_ptr;
    logic [FIFO_LOG:0]   count;
    logic [CREDIT_W-1:0] credit;
    state_t              state;

    logic          fifo_full;
    logic          fifo_empty;
    logic          wr_en;
    logic          send;
    logic [DW-1:0] head;
    logic [1:0]    head_ty;
    logic          is_head;
    logic          is_tail;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign ready_o    = ~fifo_full;
    assign wr_en      = valid_i & ~fifo_full;
    assign send       = ~fifo_empty & (credit != '0);

    assign head    = mem[rd_ptr];
    assign head_ty = head[DW-1:DW-2];
    assign is_head = (head_ty == `HEAD);
    assign is_tail = (head_ty == `TAIL);

    assign credit_o = credit;
    assign in_pkt_o = (state == BUSY);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (send) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, send})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= send;
            if (send) begin
                data_o <= head;
            end
        end
    end

    // Framing follows the sent flit type even when it flags an error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit    <= CMAX;
            state     <= IDLE;
            pkt_cnt_o <= '0;
            err_o     <= 1'b0;
        end else begin
            if (send && !credit_upd_i) begin
                credit <= credit - 1'b1;
            end else if (!send && credit_upd_i) begin
                if (credit == CMAX) begin
                    err_o <= 1'b1;
                end else begin
                    credit <= credit + 1'b1;
                end
            end
            if (send) begin
                unique case (1'b1)
                    is_head: begin
                        if (state == BUSY) begin
                            err_o <= 1'b1;
                        end
                        state <= BUSY;
                    end
                    is_tail: begin
                        if (state == IDLE) begin
                            err_o <= 1'b1;
                        end
                        state     <= IDLE;
                        pkt_cnt_o <= pkt_cnt_o + 16'd1;
                    end
                    default: begin
                        if (state == IDLE) begin
                            err_o <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
